// File: rtl/mem_arb_pkg.sv
// Shared types for the video/CPU single-port RAM arbiter: FSM states and
// the owner tags that travel alongside each issued memory read.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, PEND, WAIT, DONE} state_t;

  typedef enum logic {OWN_VID, OWN_CPU} owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_VID};

endpackage

// File: rtl/arb_tag_pipe.sv
// Delay line for read-owner tags; its output lines up with the memory's
// read data so each returned byte can be steered to video or CPU.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int P_mem_latency = 1
) (
  input  logic clk,
  input  logic srst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  localparam int TW = $bits(tag_t);

  logic [TW*(P_mem_latency+1)-1:0] chain;

  assign chain[TW-1:0] = tag_in;

  generate
    for (genvar gi = 0; gi < P_mem_latency; gi++) begin : g_stage
      tag_t stage_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          stage_reg <= TAG_NONE;
        end else begin
          stage_reg <= tag_t'(chain[gi*TW +: TW]);
        end
      end

      assign chain[(gi+1)*TW +: TW] = stage_reg;
    end
  endgenerate

  assign tag_out = tag_t'(chain[P_mem_latency*TW +: TW]);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between a strict-priority video fetch port and
// a one-deep queued CPU access; the CPU is held off through O_cpu_ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int P_addr_bits    = 15,
  parameter int P_data_bits    = 8,
  parameter int P_mem_latency  = 1,
  parameter int P_starve_limit = 8
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  input  logic [P_addr_bits-1:0] I_vid_addr,
  input  logic                   I_vid_rden,
  output logic [P_data_bits-1:0] O_vid_data,
  input  logic [P_addr_bits-1:0] I_cpu_addr,
  input  logic                   I_cpu_rden,
  input  logic                   I_cpu_wren,
  input  logic [P_data_bits-1:0] I_cpu_data,
  output logic [P_data_bits-1:0] O_cpu_data,
  output logic                   O_cpu_ready,
  output logic [P_addr_bits-1:0] O_mem_addr,
  output logic                   O_mem_rden,
  output logic                   O_mem_wren,
  output logic [P_data_bits-1:0] O_mem_data,
  input  logic [P_data_bits-1:0] I_mem_data,
  output logic                   O_starve,
  output logic                   O_overrun
);

  localparam int CW = $clog2(P_starve_limit + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(P_starve_limit);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  generate
    if (P_mem_latency < 1) begin : g_bad_latency
      $error("mem_arbiter: P_mem_latency must be at least 1");
    end
  endgenerate

  state_t                 state_reg;
  logic                   prev_req_reg;
  logic                   cpu_write_reg;
  logic [P_addr_bits-1:0] cpu_addr_reg;
  logic [P_addr_bits-1:0] mem_addr_reg;
  logic [P_data_bits-1:0] cpu_wdata_reg;
  logic [P_data_bits-1:0] cpu_rdata_reg;
  logic [P_data_bits-1:0] vid_data_reg;
  logic [CW-1:0]          wait_cnt_reg;
  logic                   starve_reg;
  logic                   overrun_reg;

  logic cpu_req, cpu_edge, vid_issue, cpu_issue, vid_hit, cpu_hit;
  tag_t tag_in, tag_out;

  assign cpu_req   = I_cpu_rden | I_cpu_wren;
  assign cpu_edge  = cpu_req & ~prev_req_reg;
  // Enables are gated by reset so nothing reaches the RAM in a reset cycle.
  assign vid_issue = I_vid_rden & ~I_reset;
  assign cpu_issue = ~I_vid_rden & (state_reg == PEND) & ~I_reset;

  always_comb begin
    O_mem_addr = mem_addr_reg;
    if (I_vid_rden) begin
      O_mem_addr = I_vid_addr;
    end else if (state_reg == PEND) begin
      O_mem_addr = cpu_addr_reg;
    end
  end

  assign O_mem_rden = vid_issue | (cpu_issue & ~cpu_write_reg);
  assign O_mem_wren = cpu_issue & cpu_write_reg;
  assign O_mem_data = cpu_wdata_reg;

  assign tag_in.valid = O_mem_rden;
  assign tag_in.owner = I_vid_rden ? OWN_VID : OWN_CPU;

  arb_tag_pipe #(
    .P_mem_latency(P_mem_latency)
  ) u_tag_pipe (
    .clk    (I_clock),
    .srst   (I_reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign vid_hit = tag_out.valid & (tag_out.owner == OWN_VID);
  assign cpu_hit = tag_out.valid & (tag_out.owner == OWN_CPU);

  // Video sees RAM data directly so its latency equals a dedicated port.
  assign O_vid_data  = vid_hit ? I_mem_data : vid_data_reg;
  assign O_cpu_data  = cpu_rdata_reg;
  assign O_cpu_ready = (state_reg == IDLE);
  assign O_starve    = starve_reg;
  assign O_overrun   = overrun_reg;

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_reg     <= IDLE;
      prev_req_reg  <= 1'b0;
      cpu_write_reg <= 1'b0;
      cpu_addr_reg  <= '0;
      mem_addr_reg  <= '0;
      cpu_wdata_reg <= '0;
      cpu_rdata_reg <= '0;
      vid_data_reg  <= '0;
      wait_cnt_reg  <= '0;
      starve_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      prev_req_reg <= cpu_req;
      mem_addr_reg <= O_mem_addr;
      if (vid_hit) vid_data_reg <= I_mem_data;
      if (cpu_hit) cpu_rdata_reg <= I_mem_data;
      if (cpu_edge && state_reg != IDLE) overrun_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (cpu_edge) begin
            cpu_addr_reg  <= I_cpu_addr;
            cpu_wdata_reg <= I_cpu_data;
            cpu_write_reg <= I_cpu_wren;
            wait_cnt_reg  <= '0;
            state_reg     <= PEND;
          end
        end
        PEND: begin
          if (cpu_issue) begin
            state_reg <= cpu_write_reg ? DONE : WAIT;
          end else begin
            if (wait_cnt_reg != STARVE_MAX) wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
            if (wait_cnt_reg + CNT_ONE >= STARVE_MAX) starve_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (cpu_hit) state_reg <= DONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM, a reference memory
// model and a per-cycle checker for video priority and video return data.
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] vid_addr;
  logic          vid_rden;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rden;
  logic          cpu_wren;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] vid_data;
  logic [DW-1:0] cpu_data;
  logic          cpu_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;
  logic          starve;
  logic          overrun;

  mem_arbiter #(
    .P_addr_bits   (AW),
    .P_data_bits   (DW),
    .P_mem_latency (1),
    .P_starve_limit(8)
  ) dut (
    .I_clock    (clk),
    .I_reset    (rst),
    .I_vid_addr (vid_addr),
    .I_vid_rden (vid_rden),
    .O_vid_data (vid_data),
    .I_cpu_addr (cpu_addr),
    .I_cpu_rden (cpu_rden),
    .I_cpu_wren (cpu_wren),
    .I_cpu_data (cpu_wdata),
    .O_cpu_data (cpu_data),
    .O_cpu_ready(cpu_ready),
    .O_mem_addr (mem_addr),
    .O_mem_rden (mem_rden),
    .O_mem_wren (mem_wren),
    .O_mem_data (mem_wdata),
    .I_mem_data (mem_q),
    .O_starve   (starve),
    .O_overrun  (overrun)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Power-up RAM contents shared by the RAM and the reference model.
  function automatic logic [7:0] init_val(input logic [14:0] a);
    case (a)
      15'h5800: return 8'h3C;
      15'h1234: return 8'h11;
      15'h0042: return 8'h77;
      15'h0200: return 8'hA1;
      15'h0300: return 8'hB2;
      15'h0400: return 8'hC3;
      15'h0500: return 8'hD4;
      default:  return a[7:0] ^ {1'b0, a[14:8]};
    endcase
  endfunction

  logic [7:0] ram [32768];
  bit         ram_wr [32768];
  logic [7:0] ref_mem [32768];
  bit         ref_wr [32768];

  function automatic logic [7:0] ram_rd(input logic [14:0] a);
    return ram_wr[a] ? ram[a] : init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [14:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_wren) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    if (mem_rden) mem_q <= ram_rd(mem_addr);
  end

  // Per-cycle checker: video always wins the port and gets its byte one cycle
  // later; between returns the video output holds.
  logic       vid_due = 1'b0;
  logic [7:0] vid_due_val = 8'h00;
  logic [7:0] vid_last = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rden", 32'(mem_rden), 0);
      chk("rst_wren", 32'(mem_wren), 0);
      vid_due  = 1'b0;
      vid_last = 8'h00;
    end else begin
      if (vid_due) begin
        chk("vid_data", 32'(vid_data), 32'(vid_due_val));
        vid_last = vid_due_val;
      end else begin
        chk("vid_hold", 32'(vid_data), 32'(vid_last));
      end
      if (vid_rden) begin
        chk("vid_prio_rden", 32'(mem_rden), 1);
        chk("vid_prio_wren", 32'(mem_wren), 0);
        chk("vid_prio_addr", 32'(mem_addr), 32'(vid_addr));
        vid_due     = 1'b1;
        vid_due_val = ref_rd(vid_addr);
      end else begin
        vid_due = 1'b0;
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vid_rden = 1'b0; vid_addr = '0;
    cpu_addr = '0; cpu_rden = 1'b0; cpu_wren = 1'b0; cpu_wdata = '0;
    repeat (3) go();
    rst = 1'b0; #3;
    chk("reset_ready", 32'(cpu_ready), 1);
    chk("reset_cpu_data", 32'(cpu_data), 0);
    chk("reset_vid_data", 32'(vid_data), 0);
    chk("reset_starve", 32'(starve), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_rden", 32'(mem_rden), 0);
    chk("reset_wren", 32'(mem_wren), 0);
    $display("txn reset: released");

    // CPU write 0x5A -> 0x6010, video idle
    go(); cpu_addr = 15'h6010; cpu_wdata = 8'h5A; cpu_wren = 1'b1;
    ref_mem[15'h6010] = 8'h5A; ref_wr[15'h6010] = 1'b1; #3;
    chk("wr_ready_n", 32'(cpu_ready), 1);
    go(); cpu_wren = 1'b0; #3;
    chk("wr_wren_n1", 32'(mem_wren), 1);
    chk("wr_addr_n1", 32'(mem_addr), 'h6010);
    chk("wr_data_n1", 32'(mem_wdata), 'h5A);
    chk("wr_ready_n1", 32'(cpu_ready), 0);
    go(); #3;
    chk("wr_wren_n2", 32'(mem_wren), 0);
    chk("wr_ready_n2", 32'(cpu_ready), 0);
    go(); #3;
    chk("wr_ready_n3", 32'(cpu_ready), 1);
    chk("wr_ram", 32'(ram_rd(15'h6010)), 'h5A);
    $display("txn cpu write addr=0x6010 data=0x5a");

    // CPU read of 0x5800 (0x3C), strobe held high across the access
    go(); cpu_addr = 15'h5800; cpu_rden = 1'b1; #3;
    go(); #3;
    chk("rd_rden_n1", 32'(mem_rden), 1);
    chk("rd_addr_n1", 32'(mem_addr), 'h5800);
    chk("rd_ready_n1", 32'(cpu_ready), 0);
    go(); #3;
    chk("rd_ready_n2", 32'(cpu_ready), 0);
    go(); #3;
    chk("rd_data_n3", 32'(cpu_data), 'h3C);
    chk("rd_ready_n3", 32'(cpu_ready), 0);
    go(); cpu_rden = 1'b0; #3;
    chk("rd_ready_n4", 32'(cpu_ready), 1);
    $display("txn cpu read addr=0x5800 data=0x%0h", cpu_data);

    // CPU read of 0x0042 starved by 12 back-to-back video reads
    go(); cpu_addr = 15'h0042; cpu_rden = 1'b1; #3;
    go(); cpu_rden = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) go();
      vid_rden = 1'b1; vid_addr = 15'(32'h0100 + k); #3;
      chk("starve_flag", 32'(starve), 32'(k >= 9));
      chk("starve_ready", 32'(cpu_ready), 0);
    end
    go(); vid_rden = 1'b0; #3;
    chk("starve_issue_rden", 32'(mem_rden), 1);
    chk("starve_issue_addr", 32'(mem_addr), 'h0042);
    go(); #3;
    go(); #3;
    chk("starve_cpu_data", 32'(cpu_data), 'h77);
    go(); #3;
    chk("starve_ready_end", 32'(cpu_ready), 1);
    chk("starve_sticky", 32'(starve), 1);
    $display("txn cpu read addr=0x0042 under video load starve=%0d", starve);

    // Reset while a write is pending: the write must never reach the RAM
    go(); cpu_addr = 15'h1234; cpu_wdata = 8'hEE; cpu_wren = 1'b1; #3;
    go(); cpu_wren = 1'b0; rst = 1'b1; #3;
    chk("rstw_wren", 32'(mem_wren), 0);
    go(); rst = 1'b0; #3;
    chk("rstw_ready", 32'(cpu_ready), 1);
    chk("rstw_starve_clr", 32'(starve), 0);
    chk("rstw_ram", 32'(ram_rd(15'h1234)), 'h11);
    $display("txn reset mid-write addr=0x1234 dropped");

    // Video read and CPU edge in the same cycle
    go(); vid_rden = 1'b1; vid_addr = 15'h0200; cpu_rden = 1'b1; cpu_addr = 15'h0300; #3;
    chk("same_addr_n", 32'(mem_addr), 'h0200);
    go(); vid_rden = 1'b0; cpu_rden = 1'b0; #3;
    chk("same_cpu_rden", 32'(mem_rden), 1);
    chk("same_cpu_addr", 32'(mem_addr), 'h0300);
    chk("same_vid_n1", 32'(vid_data), 'hA1);
    go(); #3;
    chk("same_vid_n2", 32'(vid_data), 'hA1);
    go(); #3;
    chk("same_cpu_data", 32'(cpu_data), 'hB2);
    chk("same_vid_n3", 32'(vid_data), 'hA1);
    go(); #3;
    chk("same_ready", 32'(cpu_ready), 1);
    $display("txn shared cycle vid=0x%0h cpu=0x%0h", vid_data, cpu_data);

    // Second rising edge while the first read is in WAIT
    go(); cpu_rden = 1'b1; cpu_addr = 15'h0400; #3;
    chk("ovr_flag_n", 32'(overrun), 0);
    go(); cpu_rden = 1'b0; #3;
    chk("ovr_issue_addr", 32'(mem_addr), 'h0400);
    go(); cpu_rden = 1'b1; cpu_addr = 15'h0500; #3;
    chk("ovr_ready_n2", 32'(cpu_ready), 0);
    go(); cpu_rden = 1'b0; #3;
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_cpu_data", 32'(cpu_data), 'hC3);
    go(); #3;
    chk("ovr_ready_n4", 32'(cpu_ready), 1);
    chk("ovr_no_issue_n4", 32'(mem_rden), 0);
    go(); #3;
    chk("ovr_no_issue_n5", 32'(mem_rden), 0);
    chk("ovr_data_hold", 32'(cpu_data), 'hC3);
    $display("txn overrun second request dropped overrun=%0d", overrun);

    go();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
